radix4_butterfly: RTL and testbench

- Radix-4 DIF butterfly stage. Sits directly upstream of the twiddle multiplier in the radix-4 FFT datapath.
- Collects groups of four consecutive complex samples (a, b, c, d) from a serial stream and computes the 4-point DFT.
- Emits X0..X3 serially, one per cycle. out_idx tags each result so the downstream stage selects the matching twiddle factor.
- Complex words are packed {re, im}, two's complement, same format the twiddler consumes.

---
 rtl/radix4_butterfly.sv | 135 +++++++++++++
 tb/tb_radix4_butterfly.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/radix4_butterfly.sv
// Radix-4 DIF butterfly: gathers a,b,c,d from a serial stream and emits the 4-point DFT X0..X3 serially.
// Latency: X0 is registered one edge after leg d is accepted; X0..X3 follow on four consecutive edges.
// No backpressure: the input is never stalled, and a group completing during X3 leads straight into its X0.
module radix4_butterfly #(
    parameter int DW    = 11,
    parameter int SHIFT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            in_sync,
    input  logic [2*DW-1:0] in_data,
    output logic            out_valid,
    output logic [2*DW-1:0] out_data,
    output logic [1:0]      out_idx
);

    // Sums need two extra bits so that four full-scale legs cannot wrap before scaling.
    localparam int SW = DW + 2;
    typedef logic signed [SW-1:0] sw_t;

    logic [1:0]      leg_cnt;
    logic [2*DW-1:0] hold_a;
    logic [2*DW-1:0] hold_b;
    logic [2*DW-1:0] hold_c;
    logic [2*DW-1:0] bank [4];
    logic [2*DW-1:0] res  [4];
    logic            out_act;
    logic [1:0]      out_cnt;
    logic            grp_done;

    sw_t ar, ai, br, bi, cr, ci, dr, di;
    sw_t x0r, x0i, x1r, x1i, x2r, x2i, x3r, x3i;

    function automatic sw_t re_of(input logic [2*DW-1:0] w);
        return sw_t'(signed'(w[2*DW-1:DW]));
    endfunction

    function automatic sw_t im_of(input logic [2*DW-1:0] w);
        return sw_t'(signed'(w[DW-1:0]));
    endfunction

    // Arithmetic shift rounds toward minus infinity; the low DW bits are kept.
    function automatic logic [DW-1:0] scale(input sw_t s);
        sw_t t;
        t = s >>> SHIFT;
        return t[DW-1:0];
    endfunction

    // A sync-tagged sample always restarts the group, so it can never complete one.
    assign grp_done = in_valid && !in_sync && (leg_cnt == 2'd3);

    // Four-point DFT of the held legs and the incoming leg d.
    always_comb begin
        ar  = re_of(hold_a);
        ai  = im_of(hold_a);
        br  = re_of(hold_b);
        bi  = im_of(hold_b);
        cr  = re_of(hold_c);
        ci  = im_of(hold_c);
        dr  = re_of(in_data);
        di  = im_of(in_data);
        x0r = ar + br + cr + dr;
        x0i = ai + bi + ci + di;
        x1r = ar + bi - cr - di;
        x1i = ai - br - ci + dr;
        x2r = ar - br + cr - dr;
        x2i = ai - bi + ci - di;
        x3r = ar - bi - cr + di;
        x3i = ai + br - ci - dr;
        res[0] = {scale(x0r), scale(x0i)};
        res[1] = {scale(x1r), scale(x1i)};
        res[2] = {scale(x2r), scale(x2i)};
        res[3] = {scale(x3r), scale(x3i)};
    end

    // Leg counter and holding registers; a sync sample becomes leg a and drops any partial group.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            leg_cnt <= 2'd0;
            hold_a  <= '0;
            hold_b  <= '0;
            hold_c  <= '0;
        end else if (in_valid) begin
            if (in_sync) begin
                hold_a  <= in_data;
                leg_cnt <= 2'd1;
            end else begin
                case (leg_cnt)
                    2'd0:    hold_a <= in_data;
                    2'd1:    hold_b <= in_data;
                    2'd2:    hold_c <= in_data;
                    default: ;
                endcase
                leg_cnt <= leg_cnt + 2'd1;
            end
        end
    end

    // Result bank, written on the edge that accepts leg d.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) bank[i] <= '0;
        end else if (grp_done) begin
            for (int i = 0; i < 4; i++) bank[i] <= res[i];
        end
    end

    // Output sequencer; a new group completing on the X3 edge restarts at X0 with no bubble,
    // and the X3 read on that edge still sees the previous bank contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= 2'd0;
            out_act   <= 1'b0;
            out_cnt   <= 2'd0;
        end else begin
            if (out_act) begin
                out_valid <= 1'b1;
                out_data  <= bank[out_cnt];
                out_idx   <= out_cnt;
                out_cnt   <= out_cnt + 2'd1;
                if (out_cnt == 2'd3) out_act <= 1'b0;
            end else begin
                out_valid <= 1'b0;
            end
            if (grp_done) begin
                out_act <= 1'b1;
                out_cnt <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_radix4_butterfly.sv
// Directed bench for radix4_butterfly with a scoreboard of expected (idx, data) results.
// Expected results are queued when a group is driven and checked as each output appears.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_radix4_butterfly;

    localparam int DW = 11;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_sync;
    logic [2*DW-1:0] in_data;
    logic            out_valid;
    logic [2*DW-1:0] out_data;
    logic [1:0]      out_idx;

    typedef struct packed {
        logic [1:0]      idx;
        logic [2*DW-1:0] dat;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   passed  = 0;
    int   run_len = 0;
    int   run_max = 0;

    radix4_butterfly #(.DW(DW), .SHIFT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sync   (in_sync),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [2*DW-1:0] pk(input int re, input int im);
        logic [DW-1:0] r;
        logic [DW-1:0] i;
        r = DW'(re);
        i = DW'(im);
        return {r, i};
    endfunction

    function automatic int sre(input logic [2*DW-1:0] w);
        logic signed [DW-1:0] t;
        t = w[2*DW-1:DW];
        return int'(t);
    endfunction

    function automatic int sim(input logic [2*DW-1:0] w);
        logic signed [DW-1:0] t;
        t = w[DW-1:0];
        return int'(t);
    endfunction

    // Divide by 4 rounding toward minus infinity.
    function automatic int fdiv4(input int s);
        int q;
        q = s / 4;
        if ((s % 4) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    function automatic void push(input logic [2*DW-1:0] w0, input logic [2*DW-1:0] w1,
                                 input logic [2*DW-1:0] w2, input logic [2*DW-1:0] w3);
        sb.push_back({2'd0, w0});
        sb.push_back({2'd1, w1});
        sb.push_back({2'd2, w2});
        sb.push_back({2'd3, w3});
    endfunction

    // Reference 4-point DFT with the 1/4 scaling.
    function automatic void push_model(input logic [2*DW-1:0] a, input logic [2*DW-1:0] b,
                                       input logic [2*DW-1:0] c, input logic [2*DW-1:0] d);
        int ar, ai, br, bi, cr, ci, dr, di;
        ar = sre(a); ai = sim(a); br = sre(b); bi = sim(b);
        cr = sre(c); ci = sim(c); dr = sre(d); di = sim(d);
        push(pk(fdiv4(ar + br + cr + dr), fdiv4(ai + bi + ci + di)),
             pk(fdiv4(ar + bi - cr - di), fdiv4(ai - br - ci + dr)),
             pk(fdiv4(ar - br + cr - dr), fdiv4(ai - bi + ci - di)),
             pk(fdiv4(ar - bi - cr + di), fdiv4(ai + br - ci - dr)));
    endfunction

    function automatic logic [2*DW-1:0] rnd_word();
        return pk(int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2047)) - 1024);
    endfunction

    // Output monitor: every valid output must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            run_len = run_len + 1;
            if (run_len > run_max) run_max = run_len;
            checks++;
            assert (sb.size() != 0) passed++;
            else $error("FAIL unexpected_output: got idx=%0d data=%h, required no output", out_idx, out_data);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                assert (out_data === e.dat) passed++;
                else $error("FAIL out_data[idx %0d]: got %h (%0d,%0d), required %h (%0d,%0d)",
                            e.idx, out_data, sre(out_data), sim(out_data), e.dat, sre(e.dat), sim(e.dat));
                checks++;
                assert (out_idx === e.idx) passed++;
                else $error("FAIL out_idx: got %0d, required %0d", out_idx, e.idx);
            end
        end else begin
            run_len = 0;
        end
    end

    // One sample, starting and ending on a falling edge.
    task automatic send(input logic [2*DW-1:0] w, input logic sync);
        in_valid = 1'b1;
        in_sync  = sync;
        in_data  = w;
        @(negedge clk);
        in_valid = 1'b0;
        in_sync  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_grp(input logic [2*DW-1:0] a, input logic [2*DW-1:0] b,
                            input logic [2*DW-1:0] c, input logic [2*DW-1:0] d, input int gap_max);
        send(a, 1'b1);
        idle(int'($urandom_range(0, gap_max)));
        send(b, 1'b0);
        idle(int'($urandom_range(0, gap_max)));
        send(c, 1'b0);
        idle(int'($urandom_range(0, gap_max)));
        send(d, 1'b0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        assert (sb.size() == 0) passed++;
        else $error("FAIL drain_%s: got %0d results outstanding, required 0", tag, sb.size());
        idle(2);
    endtask

    initial begin
        logic [2*DW-1:0] g [12];
        rst      = 1'b0;
        in_valid = 1'b0;
        in_sync  = 1'b0;
        in_data  = '0;

        // Reset held while samples are offered.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = pk(100, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            assert (out_valid === 1'b0 && out_data === '0 && out_idx === 2'd0) passed++;
            else $error("FAIL reset_state: got valid=%b data=%h idx=%0d, required 0/0/0",
                        out_valid, out_data, out_idx);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        idle(1);

        // Four samples of (100,0); no output until the fourth.
        send(pk(100, 0), 1'b0);
        send(pk(100, 0), 1'b0);
        send(pk(100, 0), 1'b0);
        idle(3);
        checks++;
        assert (out_valid === 1'b0) passed++;
        else $error("FAIL early_output: got valid=%b after 3 samples, required 0", out_valid);
        push(pk(100, 0), pk(0, 0), pk(0, 0), pk(0, 0));
        send(pk(100, 0), 1'b0);
        drain("dc");
        checks++;
        assert (out_data === pk(0, 0)) passed++;
        else $error("FAIL hold_last: got %h, required %h", out_data, pk(0, 0));

        // a=(4,0), b=(0,4).
        push(pk(1, 1), pk(2, 0), pk(1, -1), pk(0, 0));
        send_grp(pk(4, 0), pk(0, 4), pk(0, 0), pk(0, 0), 0);
        drain("j");

        // Truncation toward minus infinity.
        push(pk(-1, 0), pk(-1, 0), pk(-1, 0), pk(-1, 0));
        send_grp(pk(-1, 0), pk(0, 0), pk(0, 0), pk(0, 0), 0);
        drain("trunc");

        // Full negative scale, preceded by a partial group abandoned by a resync.
        send(pk(7, 7), 1'b1);
        send(pk(3, -3), 1'b0);
        idle(2);
        push(pk(-1024, -1024), pk(0, 0), pk(0, 0), pk(0, 0));
        send_grp(pk(-1024, -1024), pk(-1024, -1024), pk(-1024, -1024), pk(-1024, -1024), 0);
        drain("resync_min");

        // Three groups back to back: twelve contiguous outputs.
        for (int i = 0; i < 12; i++) g[i] = rnd_word();
        #1;
        run_len = 0;
        run_max = 0;
        for (int k = 0; k < 3; k++) begin
            push_model(g[4*k], g[4*k+1], g[4*k+2], g[4*k+3]);
            send_grp(g[4*k], g[4*k+1], g[4*k+2], g[4*k+3], 0);
        end
        drain("stream");
        checks++;
        assert (run_max == 12) passed++;
        else $error("FAIL contiguous_run: got %0d valid cycles in a row, required 12", run_max);

        // Same data with random gaps.
        for (int k = 0; k < 3; k++) begin
            push_model(g[4*k], g[4*k+1], g[4*k+2], g[4*k+3]);
            send_grp(g[4*k], g[4*k+1], g[4*k+2], g[4*k+3], 3);
        end
        drain("gaps");

        // Reset during X1 output.
        sb.push_back({2'd0, pk(1, 1)});
        sb.push_back({2'd1, pk(2, 0)});
        send_grp(pk(4, 0), pk(0, 4), pk(0, 0), pk(0, 0), 0);
        idle(2);
        #1 rst = 1'b0;
        #1;
        checks++;
        assert (out_valid === 1'b0 && out_data === '0) passed++;
        else $error("FAIL reset_mid_output: got valid=%b data=%h, required 0/0", out_valid, out_data);
        checks++;
        assert (sb.size() == 0) passed++;
        else $error("FAIL reset_mid_output_seen: got %0d results outstanding, required 0", sb.size());
        @(negedge clk);
        rst = 1'b1;
        idle(1);
        push(pk(-1, 0), pk(-1, 0), pk(-1, 0), pk(-1, 0));
        send(pk(-1, 0), 1'b0);
        send(pk(0, 0), 1'b0);
        send(pk(0, 0), 1'b0);
        send(pk(0, 0), 1'b0);
        drain("after_reset");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
